// File: rtl/coefs_pkg.sv
// ============================================================================
// Module      : coefs_pkg
// Description : Shared state encoding, host op codes and default widths for
//               the coefficient RAM host controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package coefs_pkg;

    localparam int ADDR_W_DEFAULT = 14;
    localparam int DATA_W_DEFAULT = 36;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD_A = 3'd2,
        RD_D = 3'd3,
        RSP  = 3'd4,
        CLR  = 3'd5
    } coefsState_t;

endpackage

`default_nettype wire

// File: rtl/coefs_host_ctrl.sv
// ============================================================================
// Module      : coefs_host_ctrl
// Description : Host command controller for the left/right coefficient RAMs:
//               single-word write/read, whole-channel clear, error response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coefs_host_ctrl
    import coefs_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              cmd_chan,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [ADDR_W-1:0] addrLrw,
    output logic [ADDR_W-1:0] addrRrw,
    output logic [DATA_W-1:0] datainLrw,
    output logic [DATA_W-1:0] datainRrw,
    output logic              weL,
    output logic              weR,
    input  logic [DATA_W-1:0] dataoutLrw,
    input  logic [DATA_W-1:0] dataoutRrw
);

    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_LAST = {ADDR_W{1'b1}};

    coefsState_t       r_state;
    coefsState_t       w_stateNext;
    logic [1:0]        r_op;
    logic              r_chan;
    logic [ADDR_W-1:0] r_addrL;
    logic [ADDR_W-1:0] r_addrR;
    logic [DATA_W-1:0] r_datainL;
    logic [DATA_W-1:0] r_datainR;
    logic [DATA_W-1:0] r_rspData;

    logic              w_accept;
    logic              w_writing;
    logic [ADDR_W-1:0] w_selAddr;
    logic              w_clrLast;

    assign cmd_ready = (r_state == IDLE) && !reset;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_selAddr = r_chan ? r_addrR : r_addrL;
    assign w_clrLast = (w_selAddr == c_ADDR_LAST);

    // Write strobes are gated by reset so an aborting cycle touches no RAM.
    assign w_writing = ((r_state == WR) || (r_state == CLR)) && !reset;
    assign weL       = w_writing && !r_chan;
    assign weR       = w_writing && r_chan;

    assign busy      = (r_state != IDLE) && !reset;
    assign rsp_valid = (r_state == RSP) && !reset;
    assign rsp_err   = rsp_valid && (r_op == OP_RSV);
    assign rsp_data  = r_rspData;

    assign addrLrw   = r_addrL;
    assign addrRrw   = r_addrR;
    assign datainLrw = r_datainL;
    assign datainRrw = r_datainR;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    unique case (cmd_op)
                        OP_WR:   w_stateNext = WR;
                        OP_RD:   w_stateNext = RD_A;
                        OP_CLR:  w_stateNext = CLR;
                        default: w_stateNext = RSP;
                    endcase
                end
            end
            WR:      w_stateNext = IDLE;
            RD_A:    w_stateNext = RD_D;
            RD_D:    w_stateNext = RSP;
            RSP:     w_stateNext = IDLE;
            CLR:     w_stateNext = w_clrLast ? IDLE : CLR;
            default: w_stateNext = IDLE;
        endcase
    end

    // The selected channel's address register doubles as the clear counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_op      <= OP_WR;
            r_chan    <= 1'b0;
            r_addrL   <= '0;
            r_addrR   <= '0;
            r_datainL <= '0;
            r_datainR <= '0;
            r_rspData <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op   <= cmd_op;
                        r_chan <= cmd_chan;
                        unique case (cmd_op)
                            OP_WR: begin
                                if (cmd_chan) begin
                                    r_addrR   <= cmd_addr;
                                    r_datainR <= cmd_wdata;
                                end else begin
                                    r_addrL   <= cmd_addr;
                                    r_datainL <= cmd_wdata;
                                end
                            end
                            OP_RD: begin
                                if (cmd_chan) begin
                                    r_addrR <= cmd_addr;
                                end else begin
                                    r_addrL <= cmd_addr;
                                end
                            end
                            OP_CLR: begin
                                if (cmd_chan) begin
                                    r_addrR   <= '0;
                                    r_datainR <= '0;
                                end else begin
                                    r_addrL   <= '0;
                                    r_datainL <= '0;
                                end
                            end
                            default: r_rspData <= '0;
                        endcase
                    end
                end
                RD_D: r_rspData <= r_chan ? dataoutRrw : dataoutLrw;
                CLR: begin
                    if (!w_clrLast) begin
                        if (r_chan) begin
                            r_addrR <= r_addrR + c_ADDR_ONE;
                        end else begin
                            r_addrL <= r_addrL + c_ADDR_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
